data_ram_mmio: RTL and testbench
================================

Name: data_ram_mmio

Overview:
Responder for the CPU data SRAM port (we/addr/wdata/rdata). It decodes each access to one of three targets: a word-organised data RAM, a small memory-mapped register file (LEDs, switches, timer, done/halt), or unmapped space. Read data is returned combinationally in the same cycle, as the single-cycle core requires. Writes commit on the rising clock edge.

Parameters:
RAM_BASE, 32'h1C80_0000, byte base address of data RAM region
RAM_AW, 12, word-address width of data RAM (4096 words = 16 KB)
MMIO_BASE, 32'hBFAF_0000, byte base of 4 KB register window
INIT_FILE, "", hex image loaded into RAM at elaboration ($readmemh); empty = no init
LED_W, 16, LED register width
SW_W, 8, switch input width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data_sram_we  in  1  write strobe for current access (full word)
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  write data
data_sram_rdata  out  32  read data, combinational from addr
sw  in  SW_W  asynchronous board switches
led  out  LED_W  LED register value
done  out  1  program-finished flag
done_code  out  32  value written to DONE register
err  out  1  sticky access-error flag

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Region decode:
  - RAM hit: addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2].
  - MMIO hit: addr[31:12] == MMIO_BASE[31:12].
  - Anything else is unmapped.
- Word addressing: addr[1:0] is ignored for indexing. A write with addr[1:0] != 0 still writes the full word and sets err.
- RAM:
  - rdata = mem[addr[RAM_AW+1:2]], combinational.
  - A write updates that word at the clock edge.
  - Read-during-write to the same word in the same cycle returns the OLD value. The new value is visible from the next cycle.
  - RAM contents are not cleared by reset.
- MMIO offsets (addr[11:0]):
  - 0x000 LED: RW. Write loads wdata[LED_W-1:0]. Read returns the value zero-extended.
  - 0x004 SW: RO. Returns sw through a 2-FF synchroniser, zero-extended. A change on sw is visible in rdata 2 cycles later. Writes are ignored.
  - 0x008 TIMER: RW, 32-bit.
    - Increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
    - A write loads wdata with no increment in that cycle; a read in the next cycle returns wdata.
    - A read returns the current (pre-edge) value.
  - 0x00C DONE: RW.
    - The first write while done==0 sets done=1 and done_code=wdata.
    - Later writes are ignored; only reset clears.
    - Read returns {31'b0, done}.
  - Any other offset reads 0. A write to any other offset is ignored and sets err.
- Unmapped: reads return 32'h0. Writes are dropped and set err.
- err is sticky until reset. Its set conditions are an unmapped write, a write to an undefined MMIO offset, and a misaligned write. Reads never set err.
- Reset values: led=0, timer=0, done=0, done_code=0, err=0, synchroniser flops=0. data_sram_rdata reflects the decode immediately after reset.
- Reset mid-operation: reset has priority over any write in the same cycle. An MMIO write in the reset cycle is lost; a RAM write in that cycle still commits. The CPU gates we with valid, so none occurs in practice.
- No stall or handshake: every access completes in the cycle it is presented.

Decomposition:
- Package data_ram_mmio_pkg holds the MMIO offset constants (OFF_LED, OFF_SW, OFF_TIMER, OFF_DONE), the default base addresses, and a region enum {REG_RAM, REG_MMIO, REG_NONE}.
- One sub-module, mmio_regs, contains LED, SW synchroniser, TIMER, DONE and their read mux. The top holds the decode, the RAM array, the final rdata mux and err.

Test Plan:
- RAM write/read: write 0x1C80_0010 <= 0xDEADBEEF, then read next cycle -> rdata 0xDEADBEEF. In the write cycle itself, a same-address read returns the prior content.
- Timer: after reset, read TIMER at cycle 5 -> 5. Write 0xFFFF_FFFE, then read on the next 3 cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- LED/SW:
  - Write LED 0x1234_ABCD -> led=0xABCD and read returns 0x0000_ABCD.
  - Set sw=0x5A -> SW read returns 0x5A two cycles later, not before.
- DONE: write DONE 0x0000_0001, then write 0x0000_0002 -> done=1, done_code=0x1. Assert reset -> done=0, done_code=0.
- Errors:
  - Write to 0x0000_1000 -> err=1, and a RAM scan shows no change.
  - Write to MMIO offset 0x020 -> err=1.
  - Misaligned write to 0x1C80_0013 -> word 4 written and err=1.
  - Reads of unmapped addresses -> 0, err unchanged.
- Reset priority: assert reset in the same cycle as an LED write of 0xFFFF -> led=0 afterwards.

Source files
------------

// File: rtl/data_ram_mmio_pkg.sv
// data_ram_mmio_pkg: shared offsets, default bases and region type for the data-port responder
package data_ram_mmio_pkg;
  localparam logic [11:0] OFF_LED = 12'h000;
  localparam logic [11:0] OFF_SW = 12'h004;
  localparam logic [11:0] OFF_TIMER = 12'h008;
  localparam logic [11:0] OFF_DONE = 12'h00C;
  localparam logic [31:0] DEF_RAM_BASE = 32'h1C80_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'hBFAF_0000;
  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;
endpackage

// File: rtl/data_ram_mmio_mmio_regs.sv
// mmio_regs: LED, switch synchroniser, free-running timer and DONE latch with their read mux
module mmio_regs
  import data_ram_mmio_pkg::*;
#(
  parameter int LED_W = 16,
  parameter int SW_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [11:0]      off,
  input  logic [31:0]      wdata,
  input  logic [SW_W-1:0]  sw,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  output logic             done,
  output logic [31:0]      done_code,
  output logic             bad_off
);
  logic [SW_W-1:0] sw_q1, sw_q2;
  logic [31:0] timer;
  logic hit_led, hit_sw, hit_tmr, hit_done;
  // byte lane bits are ignored so a misaligned access still lands on its word
  assign hit_led = off[11:2] == OFF_LED[11:2];
  assign hit_sw = off[11:2] == OFF_SW[11:2];
  assign hit_tmr = off[11:2] == OFF_TIMER[11:2];
  assign hit_done = off[11:2] == OFF_DONE[11:2];
  assign bad_off = !(hit_led || hit_sw || hit_tmr || hit_done);
  always_comb
    rdata = hit_led ? 32'(led) : hit_sw ? 32'(sw_q2) : hit_tmr ? timer :
            hit_done ? {31'b0, done} : 32'h0;
  always_ff @(posedge clk)
    if (reset) begin
      led <= '0;
      timer <= '0;
      done <= 1'b0;
      done_code <= '0;
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      led <= we && hit_led ? wdata[LED_W-1:0] : led;
      timer <= we && hit_tmr ? wdata : timer + 32'd1;
      if (we && hit_done && !done) begin
        done <= 1'b1;
        done_code <= wdata;
      end
      sw_q1 <= sw;
      sw_q2 <= sw_q1;
    end
endmodule

// File: rtl/data_ram_mmio.sv
// data_ram_mmio: single-cycle data SRAM responder decoding RAM, MMIO registers and unmapped space
module data_ram_mmio
  import data_ram_mmio_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter int RAM_AW = 12,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter string INIT_FILE = "",
  parameter int LED_W = 16,
  parameter int SW_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             done,
  output logic [31:0]      done_code,
  output logic             err
);
  logic [31:0] mem [2**RAM_AW];
  region_e region;
  logic [31:0] mmio_rdata;
  logic bad_off;
  logic [RAM_AW-1:0] idx;
  assign idx = data_sram_addr[RAM_AW+1:2];
  always_comb
    region = data_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2] ? REG_RAM :
             data_sram_addr[31:12] == MMIO_BASE[31:12] ? REG_MMIO : REG_NONE;
  always_ff @(posedge clk)
    if (data_sram_we && region == REG_RAM) mem[idx] <= data_sram_wdata;
  mmio_regs #(.LED_W(LED_W), .SW_W(SW_W)) u_regs (
    .clk(clk),
    .reset(reset),
    .we(data_sram_we && region == REG_MMIO),
    .off(data_sram_addr[11:0]),
    .wdata(data_sram_wdata),
    .sw(sw),
    .rdata(mmio_rdata),
    .led(led),
    .done(done),
    .done_code(done_code),
    .bad_off(bad_off)
  );
  always_comb
    data_sram_rdata = region == REG_RAM ? mem[idx] : region == REG_MMIO ? mmio_rdata : 32'h0;
  always_ff @(posedge clk)
    if (reset) err <= 1'b0;
    else if (data_sram_we && (region == REG_NONE || (region == REG_MMIO && bad_off) ||
                              data_sram_addr[1:0] != 2'b00)) err <= 1'b1;
endmodule

// File: tb/tb_data_ram_mmio.sv
// tb_data_ram_mmio: randomized and directed accesses scored against a behavioural model
module tb_data_ram_mmio;
  localparam logic [31:0] RB = 32'h1C80_0000;
  localparam logic [31:0] MB = 32'hBFAF_0000;
  typedef struct {int c; int k; logic [31:0] e;} item_t;
  logic clk, reset = 1'b1, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata, done_code;
  logic [7:0] sw = '0;
  logic [15:0] led;
  logic done, err;
  item_t q[$];
  int cyc = 0, vectors = 0, miscompares = 0;
  logic [31:0] ram_m[int];
  logic [7:0] sw_h[int];
  logic [15:0] m_led;
  logic [31:0] m_dc, t_base;
  bit m_done, m_err, known = 0;
  int t_cyc;

  data_ram_mmio dut (
    .clk(clk), .reset(reset), .data_sram_we(we), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata), .sw(sw), .led(led),
    .done(done), .done_code(done_code), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string nm(int k);
    return k == 0 ? "rdata" : k == 1 ? "led" : k == 2 ? "done" : k == 3 ? "done_code" : "err";
  endfunction

  function automatic logic [7:0] hist(int c);
    return sw_h.exists(c) ? sw_h[c] : 8'h0;
  endfunction

  task automatic push(int k, logic [31:0] e);
    item_t it;
    it.c = cyc; it.k = k; it.e = e;
    q.push_back(it);
  endtask

  // drives one access, predicts this cycle's outputs, then advances the model past the edge
  task automatic step(bit r, bit w, logic [31:0] a, logic [31:0] d);
    int c = cyc;
    int idx = int'((a >> 2) & 32'hFFF);
    logic [31:0] off = a & 32'hFFC;
    bit is_ram = (a >> 14) == (RB >> 14);
    bit is_mmio = (a >> 12) == (MB >> 12);
    bit have = 1;
    logic [31:0] exp = 32'h0;
    reset = r; we = w; addr = a; wdata = d;
    sw_h[c] = sw;
    if (is_ram) begin
      have = ram_m.exists(idx);
      if (have) exp = ram_m[idx];
    end else if (is_mmio) begin
      have = known;
      exp = off == 0 ? {16'h0, m_led} : off == 4 ? {24'h0, hist(c - 2)} :
            off == 8 ? t_base + 32'(c - t_cyc) : off == 12 ? {31'h0, m_done} : 32'h0;
    end
    if (have) push(0, exp);
    if (known) begin
      push(1, {16'h0, m_led});
      push(2, {31'h0, m_done});
      push(3, m_dc);
      push(4, {31'h0, m_err});
    end
    if (w && is_ram) ram_m[idx] = d;
    if (r) begin
      m_led = 0; m_done = 0; m_dc = 0; m_err = 0;
      t_base = 0; t_cyc = c + 1;
      sw_h[c] = 0; sw_h[c - 1] = 0;
      known = 1;
    end else if (w) begin
      if (a[1:0] != 2'b00) m_err = 1;
      if (is_mmio) begin
        if (off == 0) m_led = d[15:0];
        else if (off == 8) begin t_base = d; t_cyc = c + 1; end
        else if (off == 12) begin
          if (!m_done) begin m_done = 1; m_dc = d; end
        end else if (off != 4) m_err = 1;
      end else if (!is_ram) m_err = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [31:0] a); step(0, 0, a, 32'h0); endtask
  task automatic wr(logic [31:0] a, logic [31:0] d); step(0, 1, a, d); endtask

  always @(negedge clk) begin
    item_t it;
    logic [31:0] act;
    while (q.size() > 0 && q[0].c <= cyc) begin
      it = q.pop_front();
      act = it.k == 0 ? rdata : it.k == 1 ? {16'h0, led} : it.k == 2 ? {31'h0, done} :
            it.k == 3 ? done_code : {31'h0, err};
      vectors++;
      if (it.c != cyc || act !== it.e) begin
        miscompares++;
        $display("FAIL %s cyc=%0d addr=%h got=%h exp=%h", nm(it.k), cyc, addr, act, it.e);
      end
    end
  end

  initial begin
    logic [31:0] a;
    @(posedge clk);
    #1;
    step(1, 0, 32'h0, 32'h0);
    step(1, 0, 32'h0, 32'h0);
    repeat (6) rd(MB + 8);
    wr(RB + 16, 32'hDEAD_BEEF);
    rd(RB + 16);
    wr(RB + 16, 32'h1111_1111);
    rd(RB + 16);
    wr(MB + 8, 32'hFFFF_FFFE);
    repeat (3) rd(MB + 8);
    wr(MB, 32'h1234_ABCD);
    rd(MB);
    sw = 8'h5A;
    repeat (3) rd(MB + 4);
    wr(MB + 12, 32'h1);
    wr(MB + 12, 32'h2);
    rd(MB + 12);
    step(1, 0, 32'h0, 32'h0);
    rd(MB + 12);
    wr(32'h0000_1000, 32'h5555_AAAA);
    foreach (ram_m[i]) rd(RB + 32'(i) * 4);
    step(1, 0, 32'h0, 32'h0);
    wr(MB + 32'h20, 32'h7777_7777);
    rd(MB + 32'h20);
    step(1, 0, 32'h0, 32'h0);
    wr(RB + 32'h13, 32'hCAFE_F00D);
    rd(RB + 16);
    step(1, 0, 32'h0, 32'h0);
    rd(32'h0);
    rd(32'hFFFF_FFFC);
    rd(RB - 4);
    rd(RB + 32'h4000);
    wr(MB, 32'h0000_0F0F);
    step(1, 1, MB, 32'h0000_FFFF);
    rd(MB);
    wr(RB + 32'h3FFC, 32'h0BAD_F00D);
    rd(RB + 32'h3FFC);
    repeat (400) begin
      int sel = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      a = sel < 5 ? RB + 32'($urandom_range(0, 31)) * 4 :
          sel < 8 ? MB + 32'($urandom_range(0, 15)) * 4 :
          sel == 8 ? (($urandom_range(0, 1) == 1) ? RB - 4 : RB + 32'h4000) : 32'($urandom);
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, a, 32'($urandom));
    end
    rd(32'h0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d got=%0d exp=0", q.size(), q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
